// File: rtl/sweeper_pkg.sv
// Shared types, constants and the MISR step function for the exhaustive
// 7-input / 2-output combinational self-test sweeper.
package sweeper_pkg;

  localparam int unsigned STIM_W = 7;
  localparam int unsigned RESP_W = 2;
  localparam int unsigned SIG_W  = 16;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [SIG_W-1:0]  MISR_POLY = 16'h1021;
  localparam logic [SIG_W-1:0]  MISR_SEED = 16'hFFFF;
  localparam logic [STIM_W-1:0] LAST_CODE = 7'd127;

  // One signature update: shift-left with feedback, then fold in the response.
  function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0]  s,
                                                 input logic [RESP_W-1:0] d);
    return ({s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? MISR_POLY : 16'h0000))
           ^ {14'b0, d};
  endfunction

endpackage

// File: rtl/vector_sweeper_misr16.sv
// 16-bit multiple-input signature register; clear reloads the seed, en folds
// one 2-bit response.
module misr16
  import sweeper_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic [RESP_W-1:0] din,
  output logic [SIG_W-1:0]  sig
);

  logic [SIG_W-1:0] r_sig;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sig <= MISR_SEED;
    end else if (clear) begin
      r_sig <= MISR_SEED;
    end else if (en) begin
      r_sig <= misr_next(r_sig, din);
    end
  end

  assign sig = r_sig;

endmodule

// File: rtl/vector_sweeper.sv
// Walks stim through all 128 codes, holds each for SETTLE cycles, compresses
// the responses into a MISR and flags pass/fail against GOLDEN.
module vector_sweeper
  import sweeper_pkg::*;
#(
  parameter int unsigned      SETTLE = 4,
  parameter logic [SIG_W-1:0] GOLDEN = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [RESP_W-1:0] resp,
  output logic [STIM_W-1:0] stim,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE - 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [STIM_W-1:0]  r_stim;
  logic [STIM_W-1:0]  w_stim_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_busy;
  logic               w_busy_nxt;
  logic               r_done;
  logic               w_done_nxt;
  logic               r_pass;
  logic               w_pass_nxt;
  logic               w_clear;
  logic               w_en;
  logic [SIG_W-1:0]   w_sig;
  logic [SIG_W-1:0]   w_sig_next;

  // Signature the MISR will hold after this SAMPLE edge; pass compares it.
  assign w_sig_next = misr_next(w_sig, resp);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_nxt = ST_SETTLE;
      ST_SETTLE: if (r_cnt == '0) w_state_nxt = ST_SAMPLE;
      ST_SAMPLE: w_state_nxt = (r_stim == LAST_CODE) ? ST_DONE : ST_SETTLE;
      ST_DONE:   if (start) w_state_nxt = ST_SETTLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_stim_nxt = r_stim;
    w_cnt_nxt  = r_cnt;
    w_busy_nxt = r_busy;
    w_done_nxt = r_done;
    w_pass_nxt = r_pass;
    w_clear    = 1'b0;
    w_en       = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        // A restart from DONE drops the previous verdict on the same edge.
        if (start) begin
          w_stim_nxt = '0;
          w_cnt_nxt  = RELOAD;
          w_busy_nxt = 1'b1;
          w_done_nxt = 1'b0;
          w_pass_nxt = 1'b0;
          w_clear    = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (r_cnt != '0) w_cnt_nxt = r_cnt - 8'd1;
      end
      ST_SAMPLE: begin
        w_en = 1'b1;
        if (r_stim == LAST_CODE) begin
          w_busy_nxt = 1'b0;
          w_done_nxt = 1'b1;
          w_pass_nxt = (w_sig_next == GOLDEN);
        end else begin
          w_stim_nxt = r_stim + 7'd1;
          w_cnt_nxt  = RELOAD;
        end
      end
      default: begin
        w_stim_nxt = r_stim;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stim <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else begin
      r_stim <= w_stim_nxt;
      r_cnt  <= w_cnt_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      r_pass <= w_pass_nxt;
    end
  end

  misr16 u_misr (
    .clk   (clk),
    .reset (reset),
    .clear (w_clear),
    .en    (w_en),
    .din   (resp),
    .sig   (w_sig)
  );

  assign stim      = r_stim;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign signature = w_sig;

endmodule

// File: tb/tb_vector_sweeper.sv
// Directed bench for vector_sweeper: table of sweeps with model signatures,
// plus idle-after-reset and asynchronous mid-sweep reset sequences.
module tb_vector_sweeper;

  // Reference signature for a full sweep; mode 0: resp=0, 1: resp=stim[1:0],
  // 2: loopback with resp[1] inverted on code 77.
  function automatic logic [15:0] model_sig(input int mode);
    logic [15:0] s;
    logic [1:0]  r;
    logic [6:0]  c;
    s = 16'hFFFF;
    for (int n = 0; n < 128; n++) begin
      c = 7'(n);
      r = (mode == 0) ? 2'b00 : c[1:0];
      if (mode == 2 && n == 77) r[1] = ~r[1];
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {14'b0, r};
    end
    return s;
  endfunction

  localparam logic [15:0] SIG_ZERO  = model_sig(0);
  localparam logic [15:0] SIG_LOOP  = model_sig(1);
  localparam logic [15:0] SIG_FAULT = model_sig(2);

  typedef struct {
    int          mode;
    int          pulse_code;
    logic [15:0] exp_sig;
    logic        exp_pass;
    logic        exp_pass_b;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  resp;
  logic [6:0]  a_stim, b_stim;
  logic        a_busy, b_busy, a_done, b_done, a_pass, b_pass;
  logic [15:0] a_sig, b_sig;
  logic        fault;
  int          resp_mode;
  int          n_pass;
  int          n_total;
  vec_t        vecs[4];

  always #5 clk = ~clk;

  assign fault = (resp_mode == 2) && (a_stim == 7'd77);
  assign resp  = (resp_mode == 0) ? 2'b00 : {a_stim[1] ^ fault, a_stim[0]};

  vector_sweeper #(.SETTLE(1), .GOLDEN(SIG_LOOP)) u_dut (
    .clk(clk), .reset(reset), .start(start), .resp(resp),
    .stim(a_stim), .busy(a_busy), .done(a_done), .pass(a_pass),
    .signature(a_sig)
  );

  vector_sweeper #(.SETTLE(1), .GOLDEN(SIG_LOOP ^ 16'h0001)) u_bad (
    .clk(clk), .reset(reset), .start(start), .resp(resp),
    .stim(b_stim), .busy(b_busy), .done(b_done), .pass(b_pass),
    .signature(b_sig)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] pack_out();
    return 32'({a_stim, a_busy, a_done, a_pass, a_sig});
  endfunction

  localparam logic [31:0] RESET_PACK = 32'({7'd0, 1'b0, 1'b0, 1'b0, 16'hFFFF});

  // Start from IDLE/DONE, follow the walk edge by edge, then check the verdict.
  task automatic run_sweep(input vec_t v);
    int stim_err;
    int done_at;
    int j;
    resp_mode = v.mode;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_state", pack_out(), 32'({7'd0, 1'b1, 1'b0, 1'b0, 16'hFFFF}));
    stim_err = 0;
    done_at  = -1;
    j = 1;
    while (j <= 400 && done_at < 0) begin
      if (v.pulse_code >= 0 && j == 2 * v.pulse_code + 1) start = 1'b1;
      tick();
      start = 1'b0;
      if (a_done) done_at = j;
      else if (a_stim !== 7'(j / 2) || a_busy !== 1'b1) stim_err++;
      j++;
    end
    check("stim_walk_errs", 32'(stim_err), 32'd0);
    check("done_edge", 32'(done_at), 32'd256);
    check("final_sig", 32'(a_sig), 32'(v.exp_sig));
    check("final_stim_busy", 32'({a_stim, a_busy}), 32'({7'd127, 1'b0}));
    check("pass", 32'(a_pass), 32'(v.exp_pass));
    check("pass_golden_xor1", 32'(b_pass), 32'(v.exp_pass_b));
  endtask

  initial begin
    int idle_err;
    n_pass    = 0;
    n_total   = 0;
    resp_mode = 0;
    start     = 1'b0;
    reset     = 1'b1;

    vecs[0] = '{0, -1, SIG_ZERO, SIG_ZERO == SIG_LOOP,
                SIG_ZERO == (SIG_LOOP ^ 16'h0001)};
    vecs[1] = '{1, -1, SIG_LOOP, 1'b1, 1'b0};
    vecs[2] = '{2, -1, SIG_FAULT, 1'b0, 1'b0};
    vecs[3] = '{1, 40, SIG_LOOP, 1'b1, 1'b0};

    repeat (3) tick();
    check("reset_values", pack_out(), RESET_PACK);
    reset = 1'b0;

    idle_err = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (pack_out() !== RESET_PACK) idle_err++;
    end
    check("idle_no_start_errs", 32'(idle_err), 32'd0);

    for (int v = 0; v < 4; v++) run_sweep(vecs[v]);

    // Asynchronous reset while code 63 is settling.
    resp_mode = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (126) tick();
    check("mid_code", 32'(a_stim), 32'd63);
    #3 reset = 1'b1;
    #1;
    check("async_reset_outputs", pack_out(), RESET_PACK);
    check("async_reset_bad_inst", 32'({b_busy, b_done, b_sig}),
          32'({1'b0, 1'b0, 16'hFFFF}));
    #2 reset = 1'b0;
    repeat (3) tick();
    check("idle_after_reset", pack_out(), RESET_PACK);
    run_sweep(vecs[1]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
